// File: rtl/output_frame_buffer.sv
// Double-banked per-port slot buffer, shifted out MSB-first as a 2*SLOTS*WIDTH-bit frame on every port.
// swap_ack/frame_start appear the cycle after the accepting edge; swaps are taken only when idle or at frame end.
module output_frame_buffer #(
    parameter int PORTS = 8,
    parameter int SLOTS = 4,
    parameter int WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [$clog2(PORTS)-1:0]  wr_port,
    input  logic [$clog2(SLOTS)-1:0]  wr_slot,
    input  logic [WIDTH-1:0]          wr_header,
    input  logic [WIDTH-1:0]          wr_payload,
    input  logic                      swap,
    input  logic                      out_en,
    output logic                      swap_ack,
    output logic                      frame_start,
    output logic                      busy,
    output logic [PORTS-1:0]          ser_out,
    output logic [PORTS-1:0]          ser_valid,
    output logic                      wr_collision
);
    localparam int SW = $clog2(SLOTS);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [SW-1:0] SLOT_LAST = SW'(SLOTS - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                            r_state;
    state_t                            w_state_nxt;
    logic                              r_bank;
    logic [1:0][PORTS-1:0][SLOTS-1:0]  r_vld;
    logic [WIDTH-1:0]                  r_hdr [2][PORTS][SLOTS];
    logic [WIDTH-1:0]                  r_pay [2][PORTS][SLOTS];
    logic [SW-1:0]                     r_slot;
    logic                              r_phase;
    logic [BW-1:0]                     r_bit;
    logic                              r_ack;
    logic                              r_coll;
    logic                              w_rd_bank;
    logic                              w_last;
    logic                              w_accept;
    logic                              w_on;

    assign w_rd_bank = ~r_bank;
    assign w_last    = (r_state == SHIFT) && (r_slot == SLOT_LAST) && r_phase && (r_bit == BIT_LAST);
    assign w_accept  = swap && ((r_state == IDLE) || w_last);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = SHIFT;
            SHIFT:   if (w_last) w_state_nxt = w_accept ? SHIFT : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bank  <= 1'b0;
            r_vld   <= '0;
            r_slot  <= '0;
            r_phase <= 1'b0;
            r_bit   <= '0;
            r_ack   <= 1'b0;
            r_coll  <= 1'b0;
        end else begin
            r_ack  <= w_accept;
            r_coll <= wr_en && r_vld[r_bank][wr_port][wr_slot];
            // Read-bank clear and write-bank set never touch the same bank.
            if (w_last) r_vld[w_rd_bank] <= '0;
            if (wr_en)  r_vld[r_bank][wr_port][wr_slot] <= 1'b1;
            if (w_accept) begin
                r_bank  <= ~r_bank;
                r_slot  <= '0;
                r_phase <= 1'b0;
                r_bit   <= '0;
            end else if (r_state == SHIFT) begin
                if (r_bit == BIT_LAST) begin
                    r_bit   <= '0;
                    r_phase <= ~r_phase;
                    if (r_phase) r_slot <= r_slot + 1'b1;
                end else begin
                    r_bit <= r_bit + 1'b1;
                end
            end
        end
    end

    // Word storage is left unreset; the valid bits gate everything it drives.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            r_hdr[r_bank][wr_port][wr_slot] <= wr_header;
            r_pay[r_bank][wr_port][wr_slot] <= wr_payload;
        end
    end

    assign w_on         = (r_state == SHIFT) && !rst;
    assign busy         = w_on;
    assign swap_ack     = r_ack && !rst;
    assign frame_start  = r_ack && !rst;
    assign wr_collision = r_coll && !rst;

    always_comb begin
        ser_out   = '0;
        ser_valid = '0;
        for (int p = 0; p < PORTS; p++) begin
            if (w_on && out_en && r_vld[w_rd_bank][p][r_slot]) begin
                ser_valid[p] = 1'b1;
                ser_out[p]   = r_phase ? r_pay[w_rd_bank][p][r_slot][BIT_LAST - r_bit]
                                       : r_hdr[w_rd_bank][p][r_slot][BIT_LAST - r_bit];
            end
        end
    end
endmodule
